// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-length codes,
// controller state encoding and the byte count of an access length.
package dmem_pkg;

    typedef enum logic [1:0] {
        LEN_NONE = 2'b00,
        LEN_BYTE = 2'b01,
        LEN_HALF = 2'b10,
        LEN_WORD = 2'b11
    } len_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            LEN_WORD: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins; with both requesting, the
// one not granted most recently wins. After reset request 0 is favoured.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // last_one is high when request 1 was the most recent grant.
    logic last_one;

    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] && (!req[1] || last_one);
        grant[1] = req[1] && !grant[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_one <= 1'b1;
        end else if (advance) begin
            last_one <= grant[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// One transaction in flight: IDLE (accept) -> ACCESS (memory cycle) -> DONE (completion).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 100,
    parameter int ADDR_W    = 32
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,

    input  logic              REQ0_valid,
    input  logic              REQ0_write,
    input  logic [1:0]        REQ0_length,
    input  logic              REQ0_signed,
    input  logic [ADDR_W-1:0] REQ0_address,
    input  logic [31:0]       REQ0_wdata,
    output logic              REQ0_ready,
    output logic              REQ0_rvalid,
    output logic [31:0]       REQ0_rdata,
    output logic              REQ0_error,

    input  logic              REQ1_valid,
    input  logic              REQ1_write,
    input  logic [1:0]        REQ1_length,
    input  logic              REQ1_signed,
    input  logic [ADDR_W-1:0] REQ1_address,
    input  logic [31:0]       REQ1_wdata,
    output logic              REQ1_ready,
    output logic              REQ1_rvalid,
    output logic [31:0]       REQ1_rdata,
    output logic              REQ1_error,

    output logic [1:0]        MEM_write_length,
    output logic [1:0]        MEM_read_length,
    output logic              MEM_read_signed,
    output logic [31:0]       MEM_write_data,
    output logic [ADDR_W-1:0] MEM_write_address,
    output logic [ADDR_W-1:0] MEM_read_address,
    input  logic [31:0]       MEM_read_data,

    output state_t            fsm_state
);

    // Handshake: a requester holds valid and its fields stable until ready;
    // ready is a one-cycle pulse issued only in IDLE, and rvalid is a one-cycle
    // pulse two cycles later carrying rdata and error.

    localparam int AW1 = ADDR_W + 1;
    localparam logic [AW1-1:0] MEM_LIMIT = AW1'(MEM_BYTES);

    state_t state, state_nx;

    logic [1:0]        grant;
    logic              accept;
    logic              cur_id;
    logic              cur_write;
    logic [1:0]        cur_len;
    logic              cur_signed;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic              cur_err;
    logic [AW1-1:0]    end_addr;
    logic              do_access;
    logic [31:0]       load_val;
    logic [31:0]       result;

    assign accept = (state == ST_IDLE) && !SYS_reset && (grant != 2'b00);

    rr_arbiter2 u_rr (
        .clk     (SYS_clk),
        .reset   (SYS_reset),
        .req     ({REQ1_valid, REQ0_valid}),
        .advance (accept),
        .grant   (grant)
    );

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (accept) state_nx = ST_ACCESS;
            ST_ACCESS: state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            cur_id     <= 1'b0;
            cur_write  <= 1'b0;
            cur_len    <= LEN_NONE;
            cur_signed <= 1'b0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
        end else if (accept) begin
            cur_id     <= grant[1];
            cur_write  <= grant[1] ? REQ1_write   : REQ0_write;
            cur_len    <= grant[1] ? REQ1_length  : REQ0_length;
            cur_signed <= grant[1] ? REQ1_signed  : REQ0_signed;
            cur_addr   <= grant[1] ? REQ1_address : REQ0_address;
            cur_wdata  <= grant[1] ? REQ1_wdata   : REQ0_wdata;
        end
    end

    // One extra bit keeps address+bytes from wrapping near the top of the space.
    assign end_addr = {1'b0, cur_addr} + AW1'(len_bytes(cur_len));
    assign cur_err  = (cur_len == LEN_NONE) || (end_addr > MEM_LIMIT);

    // Reset gates the memory strobes so an aborted store never lands.
    assign do_access = (state == ST_ACCESS) && !SYS_reset && !cur_err;

    always_comb begin
        MEM_write_length  = LEN_NONE;
        MEM_write_address = '0;
        MEM_write_data    = '0;
        MEM_read_length   = LEN_NONE;
        MEM_read_signed   = 1'b0;
        MEM_read_address  = '0;
        if (do_access && cur_write) begin
            MEM_write_length  = cur_len;
            MEM_write_address = cur_addr;
            MEM_write_data    = cur_wdata;
        end
        if (do_access && !cur_write) begin
            MEM_read_length  = cur_len;
            MEM_read_signed  = cur_signed;
            MEM_read_address = cur_addr;
        end
    end

    // Re-shape the returned data so upper bits never depend on the memory's own extension.
    always_comb begin
        load_val = MEM_read_data;
        case (cur_len)
            LEN_BYTE: load_val = cur_signed ? {{24{MEM_read_data[7]}}, MEM_read_data[7:0]}
                                            : {24'h0, MEM_read_data[7:0]};
            LEN_HALF: load_val = cur_signed ? {{16{MEM_read_data[15]}}, MEM_read_data[15:0]}
                                            : {16'h0, MEM_read_data[15:0]};
            default:  load_val = MEM_read_data;
        endcase
    end

    assign result = (cur_err || cur_write) ? 32'h0 : load_val;

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            REQ0_rdata <= '0;
            REQ0_error <= 1'b0;
            REQ1_rdata <= '0;
            REQ1_error <= 1'b0;
        end else if (state == ST_ACCESS) begin
            if (cur_id) begin
                REQ1_rdata <= result;
                REQ1_error <= cur_err;
            end else begin
                REQ0_rdata <= result;
                REQ0_error <= cur_err;
            end
        end
    end

    assign REQ0_ready  = accept && grant[0];
    assign REQ1_ready  = accept && grant[1];
    assign REQ0_rvalid = (state == ST_DONE) && !SYS_reset && !cur_id;
    assign REQ1_rvalid = (state == ST_DONE) && !SYS_reset && cur_id;
    assign fsm_state   = state;

endmodule
